branch_cond_unit: RTL and testbench

- Consumer side of the ZF/CF flag interface.
- Holds the architectural flag register written from the flag unit.
- Accepts branch requests from decode, evaluates a 3-bit condition code against the stored flags, and issues a next-PC redirect to fetch over a valid/ready handshake.
- Sits between the flag unit and the fetch stage.

---
 rtl/branch_cond_unit_pkg.sv | 41 ++++
 rtl/branch_cond_unit_if.sv | 37 +++
 rtl/branch_cond_unit_cond_eval.sv | 37 +++
 rtl/branch_cond_unit.sv | 179 +++++++++++++++++
 tb/tb_branch_cond_unit.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_cond_unit_pkg.sv
// ----------------------------------------------------------------------------
// branch_cond_unit_pkg
// Shared definitions for the branch condition unit:
//   - default PC/target address width (AW_DEFAULT)
//   - condition-code width and the eight condition-code constants
//   - FSM state enumeration
//   - saturating 16-bit increment helper used by the optional statistics
// ----------------------------------------------------------------------------
package branch_cond_unit_pkg;

  localparam int AW_DEFAULT = 16;
  localparam int CW         = 3;

  // Condition codes (fixed encoding)
  localparam logic [CW-1:0] COND_ALWAYS = 3'd0;
  localparam logic [CW-1:0] COND_EQ     = 3'd1;
  localparam logic [CW-1:0] COND_NE     = 3'd2;
  localparam logic [CW-1:0] COND_LT     = 3'd3;
  localparam logic [CW-1:0] COND_GE     = 3'd4;
  localparam logic [CW-1:0] COND_GT     = 3'd5;
  localparam logic [CW-1:0] COND_LE     = 3'd6;
  localparam logic [CW-1:0] COND_NEVER  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value, input logic en);
    logic [15:0] result;
    if (en && (value != 16'hFFFF)) begin
      result = value + 16'd1;
    end else begin
      result = value;
    end
    return result;
  endfunction

endpackage

// File: rtl/branch_cond_unit_if.sv
// ----------------------------------------------------------------------------
// branch_cond_unit_if
// Groups the two handshakes of the branch condition unit:
//   branch request (decode -> unit): br_valid, br_ready, br_cond, br_target, br_pc
//   redirect       (unit -> fetch) : redir_valid, redir_ready, redir_pc, redir_taken
// Modports:
//   slave  - the branch condition unit itself
//   master - the surrounding pipeline (decode + fetch side)
// ----------------------------------------------------------------------------
interface branch_cond_unit_if
  import branch_cond_unit_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) ();

  logic          br_valid;
  logic          br_ready;
  logic [CW-1:0] br_cond;
  logic [AW-1:0] br_target;
  logic [AW-1:0] br_pc;

  logic          redir_valid;
  logic          redir_ready;
  logic [AW-1:0] redir_pc;
  logic          redir_taken;

  modport slave (
    input  br_valid, br_cond, br_target, br_pc, redir_ready,
    output br_ready, redir_valid, redir_pc, redir_taken
  );

  modport master (
    output br_valid, br_cond, br_target, br_pc, redir_ready,
    input  br_ready, redir_valid, redir_pc, redir_taken
  );

endinterface

// File: rtl/branch_cond_unit_cond_eval.sv
// ----------------------------------------------------------------------------
// cond_eval
// Purely combinational condition evaluator: decides whether a condition code
// holds for a given ZF/CF pair. Kept standalone so other consumers of the
// flags (e.g. a conditional-move path) can reuse it unchanged.
// Ports:
//   cond  in  CW  condition code
//   zf    in  1   zero flag
//   cf    in  1   carry / less-than flag
//   taken out 1   condition holds
// ----------------------------------------------------------------------------
module cond_eval
  import branch_cond_unit_pkg::*;
(
  input  logic [CW-1:0] cond,
  input  logic          zf,
  input  logic          cf,
  output logic          taken
);

  // Condition truth table
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_ALWAYS: taken = 1'b1;
      COND_EQ:     taken = zf;
      COND_NE:     taken = ~zf;
      COND_LT:     taken = cf;
      COND_GE:     taken = ~cf;
      COND_GT:     taken = ~zf & ~cf;
      COND_LE:     taken = zf | cf;
      COND_NEVER:  taken = 1'b0;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_cond_unit.sv
// ----------------------------------------------------------------------------
// branch_cond_unit
// Holds the architectural ZF/CF flag register, accepts branch requests from
// decode, evaluates the condition against the stored flags and issues a
// next-PC redirect to fetch.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flag_we, zf_in, cf_in  flag register write port (accepted in every state)
//   bus (slave)         branch request and redirect handshakes
//   zf, cf              stored flags
// Optional (macro BRANCH_STATS_EN):
//   stat_branches[15:0] number of evaluated branches (saturating)
//   stat_taken[15:0]    number of taken branches (saturating)
//
// Timing: a request accepted in IDLE is evaluated in the following EVAL cycle
// and the redirect is presented from the next cycle on, held until fetch
// accepts it. A flag write on the accept edge is seen by that branch; a write
// on the EVAL edge is not (the evaluation uses the pre-edge register value).
// ----------------------------------------------------------------------------
module branch_cond_unit
  import branch_cond_unit_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flag_we,
  input  logic                zf_in,
  input  logic                cf_in,
  branch_cond_unit_if.slave   bus,
  output logic                zf,
  output logic                cf
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]         stat_branches,
  output logic [15:0]         stat_taken
`endif
);

  state_e        state_r;
  state_e        state_nxt_s;

  logic          zf_r;
  logic          cf_r;

  logic [CW-1:0] cond_r;
  logic [AW-1:0] target_r;
  logic [AW-1:0] pc_r;

  logic          br_ready_r;
  logic          redir_valid_r;
  logic [AW-1:0] redir_pc_r;
  logic          redir_taken_r;

  logic          accept_s;
  logic          eval_s;
  logic          taken_s;
  logic [AW-1:0] pc_inc_s;

  assign accept_s = (state_r == ST_IDLE) & bus.br_valid;
  assign eval_s   = (state_r == ST_EVAL);
  // Natural AW-bit wrap: all-ones + 1 = 0
  assign pc_inc_s = pc_r + {{(AW-1){1'b0}}, 1'b1};

  cond_eval u_cond_eval (
    .cond  (cond_r),
    .zf    (zf_r),
    .cf    (cf_r),
    .taken (taken_s)
  );

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.br_valid) begin
          state_nxt_s = ST_EVAL;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EVAL: state_nxt_s = ST_RESP;
      ST_RESP: begin
        if (bus.redir_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register; br_ready is registered alongside as a decode of the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      br_ready_r <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      br_ready_r <= (state_nxt_s == ST_IDLE);
    end
  end

  // Architectural flag register, writable in any state, stored verbatim
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf_r <= 1'b0;
      cf_r <= 1'b0;
    end else if (flag_we) begin
      zf_r <= zf_in;
      cf_r <= cf_in;
    end
  end

  // Request capture on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond_r   <= COND_ALWAYS;
      target_r <= {AW{1'b0}};
      pc_r     <= {AW{1'b0}};
    end else if (accept_s) begin
      cond_r   <= bus.br_cond;
      target_r <= bus.br_target;
      pc_r     <= bus.br_pc;
    end
  end

  // Redirect payload, computed in EVAL and held until the next evaluation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redir_taken_r <= 1'b0;
      redir_pc_r    <= {AW{1'b0}};
    end else if (eval_s) begin
      redir_taken_r <= taken_s;
      redir_pc_r    <= taken_s ? target_r : pc_inc_s;
    end
  end

  // Redirect valid: set leaving EVAL, cleared when fetch accepts in RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redir_valid_r <= 1'b0;
    end else if (eval_s) begin
      redir_valid_r <= 1'b1;
    end else if ((state_r == ST_RESP) && bus.redir_ready) begin
      redir_valid_r <= 1'b0;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [15:0] stat_branches_r;
  logic [15:0] stat_taken_r;

  // Saturating branch / taken counters, stepped once per evaluation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_r <= 16'h0000;
      stat_taken_r    <= 16'h0000;
    end else begin
      stat_branches_r <= sat_inc16(stat_branches_r, eval_s);
      stat_taken_r    <= sat_inc16(stat_taken_r, eval_s & taken_s);
    end
  end

  assign stat_branches = stat_branches_r;
  assign stat_taken    = stat_taken_r;
`endif

  assign bus.br_ready    = br_ready_r;
  assign bus.redir_valid = redir_valid_r;
  assign bus.redir_pc    = redir_pc_r;
  assign bus.redir_taken = redir_taken_r;
  assign zf              = zf_r;
  assign cf              = cf_r;

endmodule

// File: tb/tb_branch_cond_unit.sv
// ----------------------------------------------------------------------------
// tb_branch_cond_unit
// Self-checking bench for branch_cond_unit: directed scenarios followed by
// randomized branches, all compared against a behavioural model of the flag
// register and the condition table. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_branch_cond_unit;

  logic clk;
  logic rst_n;
  logic flag_we;
  logic zf_in;
  logic cf_in;
  logic zf;
  logic cf;
`ifdef BRANCH_STATS_EN
  logic [15:0] stat_branches;
  logic [15:0] stat_taken;
`endif

  branch_cond_unit_if #(.AW(16)) bus_if ();

  branch_cond_unit #(.AW(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flag_we (flag_we),
    .zf_in   (zf_in),
    .cf_in   (cf_in),
    .bus     (bus_if),
    .zf      (zf),
    .cf      (cf)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches (stat_branches),
    .stat_taken    (stat_taken)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  bit m_zf = 1'b0;
  bit m_cf = 1'b0;
  int m_branches = 0;
  int m_taken = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end (got timeout, expected finish)");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Condition meaning in terms of the comparison the flags record:
  // zf = "operands equal", cf = "first operand below second".
  function automatic bit ref_taken(input int code, input bit z, input bit c);
    bit equal;
    bit below;
    bit above;
    equal = z;
    below = c;
    above = !equal && !below;
    case (code)
      0: return 1'b1;
      1: return equal;
      2: return !equal;
      3: return below;
      4: return !below;
      5: return above;
      6: return !above;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_stats(input string tag);
`ifdef BRANCH_STATS_EN
    check_val({tag, "_stat_br"}, {16'h0, stat_branches}, m_branches);
    check_val({tag, "_stat_tk"}, {16'h0, stat_taken}, m_taken);
`endif
  endtask

  // One complete branch transaction. Called and returns just after a falling edge.
  //   aw/az/ac : flag write presented with the request (accept edge)
  //   ew/ez/ec : flag write presented during EVAL
  //   stall    : cycles redir_ready is held low in RESP
  //   offer    : keep presenting a fresh request during the stall
  task automatic run_branch(input string tag, input int code, input int tgt, input int pc,
                            input bit aw, input bit az, input bit ac,
                            input bit ew, input bit ez, input bit ec,
                            input int stall, input bit offer);
    bit exp_t;
    int exp_pc;
    check_val({tag, "_rdy_idle"}, bus_if.br_ready, 1);
    bus_if.br_valid  = 1'b1;
    bus_if.br_cond   = code[2:0];
    bus_if.br_target = tgt[15:0];
    bus_if.br_pc     = pc[15:0];
    flag_we = aw; zf_in = az; cf_in = ac;
    if (aw) begin
      m_zf = az; m_cf = ac;
    end
    exp_t  = ref_taken(code, m_zf, m_cf);
    exp_pc = exp_t ? tgt : ((pc + 1) % 65536);
    @(negedge clk);
    // EVAL cycle
    bus_if.br_valid = 1'b0;
    flag_we = ew; zf_in = ez; cf_in = ec;
    check_val({tag, "_eval_nv"}, bus_if.redir_valid, 0);
    check_val({tag, "_eval_rdy"}, bus_if.br_ready, 0);
    if (ew) begin
      m_zf = ez; m_cf = ec;
    end
    m_branches++;
    if (exp_t) m_taken++;
    @(negedge clk);
    // RESP
    flag_we = 1'b0;
    check_val({tag, "_valid"}, bus_if.redir_valid, 1);
    check_val({tag, "_pc"}, bus_if.redir_pc, exp_pc);
    check_val({tag, "_taken"}, bus_if.redir_taken, exp_t);
    check_val({tag, "_flags"}, {zf, cf}, {m_zf, m_cf});
    check_stats(tag);
    for (int i = 0; i < stall; i++) begin
      if (offer) begin
        bus_if.br_valid  = 1'b1;
        bus_if.br_cond   = 3'($urandom_range(0, 7));
        bus_if.br_target = 16'($urandom);
        bus_if.br_pc     = 16'($urandom);
      end
      @(negedge clk);
      check_val({tag, "_st_valid"}, bus_if.redir_valid, 1);
      check_val({tag, "_st_pc"}, bus_if.redir_pc, exp_pc);
      check_val({tag, "_st_taken"}, bus_if.redir_taken, exp_t);
      check_val({tag, "_st_rdy"}, bus_if.br_ready, 0);
    end
    bus_if.br_valid    = 1'b0;
    bus_if.redir_ready = 1'b1;
    @(negedge clk);
    bus_if.redir_ready = 1'b0;
    check_val({tag, "_done_nv"}, bus_if.redir_valid, 0);
    check_val({tag, "_done_rdy"}, bus_if.br_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    flag_we = 1'b0; zf_in = 1'b0; cf_in = 1'b0;
    bus_if.br_valid = 1'b0;
    bus_if.br_cond = 3'd0;
    bus_if.br_target = 16'h0000;
    bus_if.br_pc = 16'h0000;
    bus_if.redir_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check_val("rst_valid", bus_if.redir_valid, 0);
    check_val("rst_taken", bus_if.redir_taken, 0);
    check_val("rst_pc", bus_if.redir_pc, 0);
    check_val("rst_flags", {zf, cf}, 2'b00);
    check_val("rst_rdy", bus_if.br_ready, 1);
    check_stats("rst");

    // EQ with cleared flags: not taken, falls through
    run_branch("eq0", 1, 16'h0040, 16'h0010, 0, 0, 0, 0, 0, 0, 0, 0);

    // Flag write on the accept edge is seen by the branch
    run_branch("acc_wr", 1, 16'h1234, 16'h0020, 1, 1, 0, 0, 0, 0, 0, 0);

    // Full sweep over flag combinations and all condition codes
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < 8; c++) begin
        bit fz;
        bit fc;
        fz = (f == 2);
        fc = (f == 1);
        run_branch($sformatf("sw_f%0d_c%0d", f, c), c, 16'h0200 + c, 16'h0100,
                   1, fz, fc, 0, 0, 0, 0, 0);
      end
    end

    // PC wrap-around with a 5-cycle redirect stall and a request offered meanwhile
    run_branch("wrap", 7, 16'h5555, 16'hFFFF, 0, 0, 0, 0, 0, 0, 5, 1);
    @(negedge clk);
    check_val("wrap_noacc_nv", bus_if.redir_valid, 0);
    check_val("wrap_noacc_rdy", bus_if.br_ready, 1);

    // Late flag write during EVAL is not seen by this branch, but by the next one
    run_branch("late_lt", 3, 16'h0A00, 16'h0300, 1, 0, 1, 1, 0, 0, 0, 0);
    run_branch("late_ge", 4, 16'h0B00, 16'h0301, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized branches
    for (int k = 0; k < 60; k++) begin
      run_branch($sformatf("rnd%0d", k), $urandom_range(0, 7),
                 $urandom_range(0, 65535), $urandom_range(0, 65535),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset while a redirect is pending
    flag_we = 1'b1; zf_in = 1'b1; cf_in = 1'b1;
    bus_if.br_valid = 1'b1;
    bus_if.br_cond = 3'd0;
    bus_if.br_target = 16'h7777;
    bus_if.br_pc = 16'h0400;
    @(negedge clk);
    flag_we = 1'b0;
    bus_if.br_valid = 1'b0;
    @(negedge clk);
    check_val("mid_valid_pre", bus_if.redir_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    m_zf = 1'b0; m_cf = 1'b0; m_branches = 0; m_taken = 0;
    check_val("mid_valid", bus_if.redir_valid, 0);
    check_val("mid_rdy", bus_if.br_ready, 1);
    check_val("mid_flags", {zf, cf}, 2'b00);
    check_stats("mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_nv", bus_if.redir_valid, 0);
    run_branch("post_rst", 6, 16'h0900, 16'h0500, 0, 0, 0, 0, 0, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
